// File: rtl/tanh_max_pool.sv
// 2x2 stride-2 max pooling over a captured DxD float map, one comparator, four steps per window.
// Float ordering is done on raw sign/magnitude bits; NaN/Inf are not treated specially.
module tanh_max_pool #(
    parameter int DATA_WIDTH = 32,
    parameter int D          = 4
) (
    input  logic                                 clk,
    input  logic                                 resetExternal,
    input  logic                                 startPool,
    input  logic [D*D*DATA_WIDTH-1:0]            inputMap,
    output logic [(D/2)*(D/2)*DATA_WIDTH-1:0]    pooledMap,
    output logic                                 FinishedPool
);

    localparam int H  = D / 2;
    localparam int MW = D * D * DATA_WIDTH;
    localparam int PW = H * H * DATA_WIDTH;
    localparam int WW = (H > 1) ? $clog2(H) : 1;
    localparam logic [WW-1:0] LAST = WW'(H - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state_q, state_d;
    logic                  start_prev_q, start_prev_d;
    logic [MW-1:0]         map_q, map_d;
    logic [WW-1:0]         wi_q, wi_d, wj_q, wj_d;
    logic [1:0]            step_q, step_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [PW-1:0]         pooled_q, pooled_d;
    logic                  fin_q, fin_d;

    logic [WW:0]           row, col;
    int unsigned           eidx, sidx;
    logic [DATA_WIDTH-1:0] cand, best;

    // Candidate strictly greater than accumulator under IEEE sign/magnitude ordering (+0 > -0).
    function automatic logic cand_gt(input logic [DATA_WIDTH-1:0] c,
                                     input logic [DATA_WIDTH-1:0] a);
        if (c[DATA_WIDTH-1] != a[DATA_WIDTH-1])
            return !c[DATA_WIDTH-1];
        else if (!c[DATA_WIDTH-1])
            return c[DATA_WIDTH-2:0] > a[DATA_WIDTH-2:0];
        else
            return c[DATA_WIDTH-2:0] < a[DATA_WIDTH-2:0];
    endfunction

    always_ff @(posedge clk or negedge resetExternal) begin
        if (!resetExternal) begin
            state_q      <= IDLE;
            start_prev_q <= 1'b0;
            map_q        <= '0;
            wi_q         <= '0;
            wj_q         <= '0;
            step_q       <= '0;
            acc_q        <= '0;
            pooled_q     <= '0;
            fin_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= start_prev_d;
            map_q        <= map_d;
            wi_q         <= wi_d;
            wj_q         <= wj_d;
            step_q       <= step_d;
            acc_q        <= acc_d;
            pooled_q     <= pooled_d;
            fin_q        <= fin_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        start_prev_d = startPool;
        map_d        = map_q;
        wi_d         = wi_q;
        wj_d         = wj_q;
        step_d       = step_q;
        acc_d        = acc_q;
        pooled_d     = pooled_q;
        fin_d        = fin_q;

        // Step bits select the window element: bit1 = row offset, bit0 = column offset.
        row  = {wi_q, step_q[1]};
        col  = {wj_q, step_q[0]};
        eidx = 32'(row) * D + 32'(col);
        sidx = 32'(wi_q) * H + 32'(wj_q);
        cand = map_q[eidx*DATA_WIDTH +: DATA_WIDTH];
        best = cand_gt(cand, acc_q) ? cand : acc_q;

        case (state_q)
            IDLE: begin
                if (startPool && !start_prev_q) begin
                    map_d   = inputMap;
                    wi_d    = '0;
                    wj_d    = '0;
                    step_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                step_d = step_q + 2'd1;
                acc_d  = (step_q == 2'd0) ? cand : best;
                if (step_q == 2'd3) begin
                    pooled_d[sidx*DATA_WIDTH +: DATA_WIDTH] = best;
                    if (wj_q == LAST) begin
                        wj_d = '0;
                        if (wi_q == LAST) begin
                            state_d = DONE;
                            fin_d   = 1'b1;
                        end else begin
                            wi_d = wi_q + WW'(1);
                        end
                    end else begin
                        wj_d = wj_q + WW'(1);
                    end
                end
            end
            DONE: begin
                if (!startPool) begin
                    state_d = IDLE;
                    fin_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pooledMap    = pooled_q;
    assign FinishedPool = fin_q;

endmodule

// File: tb/tb_tanh_max_pool.sv
// Bench for tanh_max_pool: directed vector table, handshake/glitch/reset sequences, random maps vs a model.
module tb_tanh_max_pool;

    localparam int D  = 4;
    localparam int DW = 32;
    localparam int H  = D / 2;
    localparam int MW = D * D * DW;
    localparam int PW = H * H * DW;
    localparam logic [31:0] ONE = 32'h3F800000;

    logic          clk = 1'b0;
    logic          resetExternal;
    logic          startPool;
    logic [MW-1:0] inputMap;
    logic [PW-1:0] pooledMap;
    logic          FinishedPool;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tanh_max_pool #(.DATA_WIDTH(DW), .D(D)) dut (
        .clk          (clk),
        .resetExternal(resetExternal),
        .startPool    (startPool),
        .inputMap     (inputMap),
        .pooledMap    (pooledMap),
        .FinishedPool (FinishedPool)
    );

    typedef struct {
        logic [MW-1:0] map;
        logic [PW-1:0] exp;
    } vec_t;

    vec_t vecs[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [MW-1:0] fill_map(input logic [31:0] v);
        logic [MW-1:0] m;
        for (int k = 0; k < D * D; k++) m[k*DW +: DW] = v;
        return m;
    endfunction

    function automatic logic [MW-1:0] set_win(input logic [MW-1:0] m, input int w,
                                              input logic [31:0] a, input logic [31:0] b,
                                              input logic [31:0] c, input logic [31:0] d);
        int i, j;
        i = w / H;
        j = w % H;
        m[((2*i)*D + 2*j)*DW +: DW]       = a;
        m[((2*i)*D + 2*j + 1)*DW +: DW]   = b;
        m[((2*i+1)*D + 2*j)*DW +: DW]     = c;
        m[((2*i+1)*D + 2*j + 1)*DW +: DW] = d;
        return m;
    endfunction

    function automatic logic [PW-1:0] pk4(input logic [31:0] s0, input logic [31:0] s1,
                                          input logic [31:0] s2, input logic [31:0] s3);
        return {s3, s2, s1, s0};
    endfunction

    // Map a float bit pattern onto a totally ordered integer: negatives below -0 below +0.
    function automatic longint fkey(input logic [31:0] v);
        longint mag;
        mag = longint'(v[30:0]);
        return v[31] ? (-mag - 1) : mag;
    endfunction

    function automatic logic [PW-1:0] model(input logic [MW-1:0] m);
        logic [PW-1:0] p;
        logic [31:0]   bestv, v;
        for (int i = 0; i < H; i++) begin
            for (int j = 0; j < H; j++) begin
                bestv = m[((2*i)*D + 2*j)*DW +: DW];
                for (int dr = 0; dr < 2; dr++) begin
                    for (int dc = 0; dc < 2; dc++) begin
                        v = m[((2*i+dr)*D + 2*j + dc)*DW +: DW];
                        if (fkey(v) > fkey(bestv)) bestv = v;
                    end
                end
                p[(i*H + j)*DW +: DW] = bestv;
            end
        end
        return p;
    endfunction

    task automatic start_run(input logic [MW-1:0] m);
        startPool = 1'b0;
        tick();
        inputMap  = m;
        startPool = 1'b1;
        tick();
    endtask

    task automatic finish_run(input int elapsed, input int busy0,
                              input logic [PW-1:0] exp, input string name);
        int busy;
        busy = busy0;
        for (int k = elapsed + 1; k <= 15; k++) begin
            tick();
            if (FinishedPool !== 1'b0) busy++;
        end
        check($sformatf("%s_busy", name), PW'(busy), PW'(0));
        tick();
        check($sformatf("%s_done", name), PW'(FinishedPool), PW'(1));
        check($sformatf("%s_map", name), pooledMap, exp);
    endtask

    task automatic do_run(input logic [MW-1:0] m, input logic [PW-1:0] exp, input string name);
        start_run(m);
        finish_run(0, 0, exp, name);
    endtask

    initial begin
        logic [31:0]   special[6];
        logic [MW-1:0] rmap;
        logic [PW-1:0] held;
        int            busy, unstable;

        special[0] = 32'h00000000; special[1] = 32'h80000000; special[2] = ONE;
        special[3] = 32'hBF800000; special[4] = 32'h7F800000; special[5] = 32'hFF800000;

        resetExternal = 1'b0;
        startPool     = 1'b0;
        inputMap      = '0;
        tick();
        tick();
        check("reset_map", pooledMap, '0);
        check("reset_fin", PW'(FinishedPool), PW'(0));
        resetExternal = 1'b1;
        tick();

        vecs[0].map = set_win(fill_map(ONE), 0, 32'h3E800000, 32'h3F000000, 32'hBF000000, 32'h3F400000);
        vecs[0].exp = pk4(32'h3F400000, ONE, ONE, ONE);
        vecs[1].map = set_win(fill_map(ONE), 1, 32'hBF000000, 32'hBE800000, 32'hBF000000, 32'hBF000000);
        vecs[1].exp = pk4(ONE, 32'hBE800000, ONE, ONE);
        vecs[2].map = set_win(fill_map(ONE), 2, 32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h3F000000);
        vecs[2].exp = pk4(ONE, ONE, 32'h3F000000, ONE);
        vecs[3].map = set_win(fill_map(ONE), 3, 32'h80000000, 32'h80000000, 32'h80000000, 32'h00000000);
        vecs[3].exp = pk4(ONE, ONE, ONE, 32'h00000000);
        vecs[4].map = fill_map(32'h80000000);
        vecs[4].exp = pk4(32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000);

        for (int v = 0; v < 5; v++) do_run(vecs[v].map, vecs[v].exp, $sformatf("vec%0d", v));

        // Handshake: hold start high after done, then drop it.
        held     = pooledMap;
        unstable = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (FinishedPool !== 1'b1 || pooledMap !== held) unstable++;
        end
        check("hold_stable", PW'(unstable), PW'(0));
        startPool = 1'b0;
        tick();
        check("drop_fin", PW'(FinishedPool), PW'(0));
        check("drop_map", pooledMap, vecs[4].exp);
        do_run(vecs[0].map, vecs[0].exp, "rerun");

        // Start glitch and map change mid-run must not disturb the run.
        start_run(vecs[1].map);
        busy = 0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (FinishedPool !== 1'b0) busy++;
        end
        startPool = 1'b0;
        tick();
        if (FinishedPool !== 1'b0) busy++;
        startPool = 1'b1;
        inputMap  = vecs[2].map;
        finish_run(6, busy, vecs[1].exp, "glitch");

        // Async reset mid-run, released with start held high.
        start_run(vecs[0].map);
        for (int k = 1; k <= 7; k++) tick();
        check("mid_slot0", PW'(pooledMap[DW-1:0]), PW'(32'h3F400000));
        resetExternal = 1'b0;
        #1;
        check("async_map", pooledMap, '0);
        check("async_fin", PW'(FinishedPool), PW'(0));
        inputMap = vecs[3].map;
        tick();
        resetExternal = 1'b1;
        tick();
        finish_run(0, 0, vecs[3].exp, "post_reset");

        for (int n = 0; n < 20; n++) begin
            for (int k = 0; k < D * D; k++) begin
                if ($urandom_range(0, 2) == 0) rmap[k*DW +: DW] = special[$urandom_range(0, 5)];
                else                           rmap[k*DW +: DW] = $urandom;
            end
            do_run(rmap, model(rmap), $sformatf("rand%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
